// File: rtl/auto_navigator.sv
// Junction navigator for auto-drive: settles on a stable detector reading, picks a
// direction by the right-hand rule, pulses one turn trigger and escorts the turn to completion.
module auto_navigator #(
   parameter int SETTLE_TIME   = 25,
   parameter int ADVANCE_TIME  = 250,
   parameter int START_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       detect_front,
   input  logic       detect_left,
   input  logic       detect_right,
   input  logic       is_turning,
   output logic       trigger_turn_left,
   output logic       trigger_turn_right,
   output logic       trigger_turn_back,
   output logic       move_forward,
   output logic [1:0] decision
);

   typedef enum logic [3:0] {
      S_IDLE, S_CRUISE, S_SETTLE, S_DECIDE, S_TRIG_L, S_TRIG_R, S_TRIG_B,
      S_WAIT_START, S_WAIT_END, S_ADVANCE
   } state_t;

   localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_TIME - 1);
   localparam logic [31:0] ADVANCE_LAST = 32'(ADVANCE_TIME - 1);
   localparam logic [31:0] START_LAST   = 32'(START_TIMEOUT - 1);
   localparam logic [2:0]  CORRIDOR     = 3'b011;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  snap_q, snap_d;
   logic [1:0]  dec_q, dec_d;
   logic        mf_q, mf_d;
   logic        trl_q, trl_d, trr_q, trr_d, trb_q, trb_d;
   logic [2:0]  det;

   assign det = {detect_front, detect_left, detect_right};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         dec_q   <= '0;
         mf_q    <= 1'b0;
         trl_q   <= 1'b0;
         trr_q   <= 1'b0;
         trb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         dec_q   <= dec_d;
         mf_q    <= mf_d;
         trl_q   <= trl_d;
         trr_q   <= trr_d;
         trb_q   <= trb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      dec_d   = dec_q;
      if (!enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_SETTLE;
               snap_d  = det;
               cnt_d   = '0;
            end
            S_CRUISE: begin
               if (det != CORRIDOR) begin
                  state_d = S_SETTLE;
                  snap_d  = det;
                  cnt_d   = '0;
               end
            end
            S_SETTLE: begin
               // any change restarts the stability window
               if (det != snap_q) begin
                  snap_d = det;
                  cnt_d  = '0;
               end else if (det == CORRIDOR) begin
                  state_d = S_CRUISE;
                  cnt_d   = '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_d = S_DECIDE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            S_DECIDE: begin
               cnt_d = '0;
               if (!detect_right) begin
                  state_d = S_TRIG_R;
                  dec_d   = 2'b10;
               end else if (!detect_front) begin
                  state_d = S_ADVANCE;
                  dec_d   = 2'b00;
               end else if (!detect_left) begin
                  state_d = S_TRIG_L;
                  dec_d   = 2'b01;
               end else begin
                  state_d = S_TRIG_B;
                  dec_d   = 2'b11;
               end
            end
            S_TRIG_L, S_TRIG_R, S_TRIG_B: begin
               state_d = S_WAIT_START;
               cnt_d   = '0;
            end
            S_WAIT_START: begin
               if (is_turning) begin
                  state_d = S_WAIT_END;
                  cnt_d   = '0;
               end else if (cnt_q == START_LAST) begin
                  state_d = S_SETTLE;
                  snap_d  = det;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            S_WAIT_END: begin
               if (!is_turning) begin
                  state_d = S_ADVANCE;
                  cnt_d   = '0;
               end
            end
            S_ADVANCE: begin
               // only an obstacle ahead may cut the clearing run short
               if (detect_front) begin
                  state_d = S_SETTLE;
                  snap_d  = det;
                  cnt_d   = '0;
               end else if (cnt_q == ADVANCE_LAST) begin
                  state_d = S_CRUISE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // outputs are decoded from the next state so they register in step with it
   always_comb begin
      mf_d  = (state_d == S_CRUISE) || (state_d == S_ADVANCE);
      trl_d = (state_d == S_TRIG_L);
      trr_d = (state_d == S_TRIG_R);
      trb_d = (state_d == S_TRIG_B);
   end

   assign trigger_turn_left  = trl_q;
   assign trigger_turn_right = trr_q;
   assign trigger_turn_back  = trb_q;
   assign move_forward       = mf_q;
   assign decision           = dec_q;

endmodule

// File: tb/tb_auto_navigator.sv
// Bench for auto_navigator: junction vector table, hand-built multi-cycle scenarios and a
// randomized run scored against a countdown-based behavioural model.
module tb_auto_navigator;
   localparam int ST = 25;
   localparam int AT = 250;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst, enable, detect_front, detect_left, detect_right, is_turning;
   logic       trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward;
   logic [1:0] decision;

   auto_navigator #(.SETTLE_TIME(ST), .ADVANCE_TIME(AT), .START_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .detect_front(detect_front), .detect_left(detect_left), .detect_right(detect_right),
      .is_turning(is_turning),
      .trigger_turn_left(trigger_turn_left), .trigger_turn_right(trigger_turn_right),
      .trigger_turn_back(trigger_turn_back), .move_forward(move_forward),
      .decision(decision)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] det;
      logic [2:0] trig;   // {left, right, back}
      logic       mf;
      logic [1:0] dec;
   } vec_t;
   vec_t vt[8];

   function automatic logic [5:0] outs();
      return {trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward, decision};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_det(input logic [2:0] d);
      {detect_front, detect_left, detect_right} = d;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; is_turning = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   // ---------------- behavioural reference (countdown timers) ----------------
   typedef enum {M_IDLE, M_CRUISE, M_SETTLE, M_DECIDE, M_TURN, M_WSTART, M_WEND, M_ADV} mst_t;
   mst_t       m_st;
   int         m_left, m_dir;
   logic [2:0] m_snap;
   logic [1:0] m_dec;

   // right-hand rule: 0 straight, 1 left, 2 right, 3 back
   function automatic int pick(input logic [2:0] d);
      if (!d[0]) return 2;
      if (!d[2]) return 0;
      if (!d[1]) return 1;
      return 3;
   endfunction

   task automatic m_settle(input logic [2:0] d);
      m_st = M_SETTLE; m_snap = d; m_left = ST;
   endtask

   task automatic model_step(input logic en, input logic [2:0] d, input logic busy);
      if (!en) begin
         m_st = M_IDLE;
         return;
      end
      case (m_st)
         M_IDLE:   m_settle(d);
         M_CRUISE: if (d != 3'b011) m_settle(d);
         M_SETTLE: begin
            if (d != m_snap) m_settle(d);
            else if (d == 3'b011) m_st = M_CRUISE;
            else begin
               m_left--;
               if (m_left == 0) m_st = M_DECIDE;
            end
         end
         M_DECIDE: begin
            m_dir = pick(d);
            m_dec = 2'(m_dir);
            if (m_dir == 0) begin m_st = M_ADV; m_left = AT; end
            else m_st = M_TURN;
         end
         M_TURN:   begin m_st = M_WSTART; m_left = TO; end
         M_WSTART: begin
            if (busy) m_st = M_WEND;
            else begin
               m_left--;
               if (m_left == 0) m_settle(d);
            end
         end
         M_WEND:   if (!busy) begin m_st = M_ADV; m_left = AT; end
         M_ADV: begin
            if (d[2]) m_settle(d);
            else begin
               m_left--;
               if (m_left == 0) m_st = M_CRUISE;
            end
         end
         default:  m_st = M_IDLE;
      endcase
   endtask

   function automatic logic [5:0] m_outs();
      logic t;
      t = (m_st == M_TURN);
      return {t && m_dir == 1, t && m_dir == 2, t && m_dir == 3,
              m_st == M_CRUISE || m_st == M_ADV, m_dec};
   endfunction

   initial begin
      int first_t, second_t, ntrig, nmf, bz_wait, bz_len;
      logic [2:0] d;

      vt[0] = '{3'b000, 3'b010, 1'b0, 2'b10};
      vt[1] = '{3'b001, 3'b000, 1'b1, 2'b00};
      vt[2] = '{3'b010, 3'b010, 1'b0, 2'b10};
      vt[3] = '{3'b011, 3'b000, 1'b1, 2'b00};
      vt[4] = '{3'b100, 3'b010, 1'b0, 2'b10};
      vt[5] = '{3'b101, 3'b100, 1'b0, 2'b01};
      vt[6] = '{3'b110, 3'b010, 1'b0, 2'b10};
      vt[7] = '{3'b111, 3'b001, 1'b0, 2'b11};

      rst = 1'b1; enable = 1'b0; is_turning = 1'b0; set_det(3'b000);
      #2;
      chk("reset_outs", 32'(outs()), 32'd0);

      // junction table: decision lands on edge 27 after a stable reading from IDLE
      foreach (vt[i]) begin
         do_reset();
         set_det(vt[i].det); enable = 1'b1;
         repeat (ST + 1) step();
         chk($sformatf("pre_trig_%03b", vt[i].det),
             32'({trigger_turn_left, trigger_turn_right, trigger_turn_back}), 32'd0);
         step();
         chk($sformatf("vec_%03b", vt[i].det), 32'(outs()),
             32'({vt[i].trig, vt[i].mf, vt[i].dec}));
         step();
         chk($sformatf("post_trig_%03b", vt[i].det),
             32'({trigger_turn_left, trigger_turn_right, trigger_turn_back}), 32'd0);
      end

      // right turn, long is_turning, then timed clearing run
      do_reset();
      set_det(3'b010); enable = 1'b1;
      ntrig = 0;
      for (int e = 0; e < ST + 3; e++) begin
         step();
         if (trigger_turn_right) ntrig++;
      end
      chk("right_single_pulse", 32'(ntrig), 32'd1);
      is_turning = 1'b1; set_det(3'b001);
      nmf = 0;
      for (int e = 0; e < 450; e++) begin
         step();
         if (move_forward) nmf++;
      end
      chk("wait_end_no_move", 32'(nmf), 32'd0);
      is_turning = 1'b0;
      nmf = 0;
      for (int e = 0; e < 400; e++) begin
         step();
         if (!move_forward) break;
         nmf++;
      end
      chk("advance_length", 32'(nmf), 32'(AT + 1));
      chk("decision_after_turn", 32'(decision), 32'b10);

      // async reset in the middle of a clearing run after a back-turn
      do_reset();
      set_det(3'b111); enable = 1'b1;
      repeat (ST + 2) step();
      chk("back_decision", 32'(outs()), 32'b001011);
      is_turning = 1'b1; repeat (3) step();
      is_turning = 1'b0; set_det(3'b001);
      repeat (100) step();
      chk("mid_advance", 32'(outs()), 32'b000111);
      #2 rst = 1'b1;
      #1 chk("async_reset_outs", 32'(outs()), 32'd0);
      step(); rst = 1'b0; set_det(3'b011); enable = 1'b1;
      step();
      chk("after_reset_settle", 32'(move_forward), 32'd0);
      step();
      chk("corridor_cruise", 32'(move_forward), 32'd1);

      ntrig = 0; nmf = 0;
      for (int e = 0; e < 1000; e++) begin
         step();
         if (trigger_turn_left || trigger_turn_right || trigger_turn_back) ntrig++;
         if (move_forward) nmf++;
      end
      chk("corridor_no_trig", 32'(ntrig), 32'd0);
      chk("corridor_mf", 32'(nmf), 32'd1000);

      // reading never stable long enough to decide
      do_reset(); enable = 1'b1;
      ntrig = 0; nmf = 0;
      for (int e = 0; e < 300; e++) begin
         if (e % 10 == 0) set_det(((e / 10) % 2 == 0) ? 3'b010 : 3'b111);
         step();
         if (trigger_turn_left || trigger_turn_right || trigger_turn_back) ntrig++;
         if (move_forward) nmf++;
      end
      chk("toggle_no_trig", 32'(ntrig), 32'd0);
      chk("toggle_no_move", 32'(nmf), 32'd0);

      // turning block never answers: timeout and retry, then abort during WAIT_END
      do_reset(); set_det(3'b010); enable = 1'b1;
      first_t = 0; second_t = 0; ntrig = 0;
      for (int e = 1; e <= (ST + 2) + 1 + TO + ST + 1; e++) begin
         step();
         if (trigger_turn_right) begin
            ntrig++;
            if (first_t == 0) first_t = e; else second_t = e;
         end
      end
      chk("retry_count", 32'(ntrig), 32'd2);
      chk("first_trig_edge", 32'(first_t), 32'(ST + 2));
      chk("second_trig_edge", 32'(second_t), 32'(ST + 2 + 1 + TO + ST + 1));
      is_turning = 1'b1;
      repeat (3) step();
      enable = 1'b0;
      step();
      chk("abort_outs", 32'({trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward}),
          32'd0);
      enable = 1'b1; set_det(3'b011);
      repeat (2) step();
      chk("abort_restart_cruise", 32'(move_forward), 32'd1);
      is_turning = 1'b0;

      // randomized run against the model
      do_reset();
      m_st = M_IDLE; m_dec = 2'b00; m_dir = 0; m_left = 0; m_snap = 3'b000;
      bz_wait = -1; bz_len = 0; d = 3'b011;
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 59) == 0) d = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom);
         set_det(d);
         enable = ($urandom_range(0, 599) != 0);
         if (bz_wait > 0) bz_wait--;
         else if (bz_wait == 0) begin bz_len = $urandom_range(3, 40); bz_wait = -1; end
         is_turning = (bz_len > 0);
         if (bz_len > 0) bz_len--;
         model_step(enable, d, is_turning);
         step();
         chk("random_outs", 32'(outs()), 32'(m_outs()));
         if (m_st == M_TURN) bz_wait = $urandom_range(0, 5);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
